// File: rtl/vga_vram_port.sv
// vga_vram_port: single-port video RAM arbiter. Video fetches and host
// req/ack accesses share the RAM on a fixed alternating slot schedule.
// Slot parity before an edge selects its role: slot=1 is a video issue
// edge, slot=0 is a host issue edge. Read data returns two edges after
// issue (registered address, synchronous RAM), so every access is
// captured on the second edge after it issued.
// Optional feature: define VRAM_VBLANK_HOST_EN to let a pending host
// request also take video slots while vid_blank_in is high.
module vga_vram_port #(
  parameter int AW = 24,
  parameter int DW = 8
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [AW-1:0] vid_address_in,
  output logic [DW-1:0] vid_data_out,
  input  logic          vid_blank_in,
  input  logic          host_req_in,
  input  logic          host_we_in,
  input  logic [AW-1:0] host_addr_in,
  input  logic [DW-1:0] host_wdata_in,
  output logic          host_busy_out,
  output logic          host_ack_out,
  output logic [DW-1:0] host_rdata_out,
  output logic [AW-1:0] mem_addr_out,
  output logic          mem_we_out,
  output logic [DW-1:0] mem_wdata_out,
  input  logic [DW-1:0] mem_rdata_in
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_HRD  = 2'd2,
    OWN_HWR  = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PEND     = 2'd1,
    ST_INFLIGHT = 2'd2
  } host_state_t;

  logic          slot;
  owner_t        owner_issue;   // who owns the access issued at the last edge
  owner_t        owner_cap;     // who owns the data arriving for this edge
  host_state_t   host_state;
  logic [AW-1:0] lat_addr;
  logic          lat_we;
  logic [DW-1:0] lat_wdata;
  logic          host_issue;
  logic          host_capture;

`ifdef VRAM_VBLANK_HOST_EN
  // Blanking lends the video slot to a pending host request.
  assign host_issue = (host_state == ST_PEND) && (!slot || vid_blank_in);
`else
  // Strict alternation: host only ever issues on slot=0 edges.
  assign host_issue = (host_state == ST_PEND) && !slot;
  logic unused_blank;
  assign unused_blank = vid_blank_in;
`endif

  assign host_capture = (owner_cap == OWN_HRD) || (owner_cap == OWN_HWR);

  // Slot phase toggles every pixel clock.
  // NOTE: all state uses non-blocking assignments so every block samples
  // pre-edge values and block ordering can never change behaviour.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) slot <= 1'b0;
    else        slot <= ~slot;
  end

  // Issue stage: drive the RAM port for this slot and tag the owner.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_addr_out  <= '0;
      mem_we_out    <= 1'b0;
      mem_wdata_out <= '0;
      owner_issue   <= OWN_NONE;
      owner_cap     <= OWN_NONE;
    end else begin
      owner_cap <= owner_issue;
      if (host_issue) begin
        mem_addr_out  <= lat_addr;
        mem_we_out    <= lat_we;
        mem_wdata_out <= lat_wdata;
        owner_issue   <= lat_we ? OWN_HWR : OWN_HRD;
      end else if (slot) begin
        mem_addr_out <= vid_address_in;
        mem_we_out   <= 1'b0;
        owner_issue  <= OWN_VID;
      end else begin
        mem_we_out  <= 1'b0;
        owner_issue <= OWN_NONE;
      end
    end
  end

  // Capture stage: route returning RAM data to its owner, pulse ack.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vid_data_out   <= '0;
      host_rdata_out <= '0;
      host_ack_out   <= 1'b0;
    end else begin
      host_ack_out <= host_capture;
      if (owner_cap == OWN_VID) vid_data_out   <= mem_rdata_in;
      if (owner_cap == OWN_HRD) host_rdata_out <= mem_rdata_in;
    end
  end

  // Host FSM: latch one request, wait for a host slot, retire on capture.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      host_state    <= ST_IDLE;
      host_busy_out <= 1'b0;
      lat_addr      <= '0;
      lat_we        <= 1'b0;
      lat_wdata     <= '0;
    end else begin
      case (host_state)
        ST_IDLE: begin
          if (host_req_in) begin
            lat_addr      <= host_addr_in;
            lat_we        <= host_we_in;
            lat_wdata     <= host_wdata_in;
            host_busy_out <= 1'b1;
            host_state    <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (host_issue) host_state <= ST_INFLIGHT;
        end
        ST_INFLIGHT: begin
          if (host_capture) begin
            host_busy_out <= 1'b0;
            host_state    <= ST_IDLE;
          end
        end
        default: begin
          host_busy_out <= 1'b0;
          host_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_vram_port.sv
// tb_vga_vram_port: directed bench for vga_vram_port with a small
// synchronous RAM model preloaded as addr[7:0]^0x5A.
module tb_vga_vram_port;
  localparam int AW = 24;
  localparam int DW = 8;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [AW-1:0] vid_address_in = '0;
  logic [DW-1:0] vid_data_out;
  logic          vid_blank_in = 1'b0;
  logic          host_req_in = 1'b0;
  logic          host_we_in = 1'b0;
  logic [AW-1:0] host_addr_in = '0;
  logic [DW-1:0] host_wdata_in = '0;
  logic          host_busy_out;
  logic          host_ack_out;
  logic [DW-1:0] host_rdata_out;
  logic [AW-1:0] mem_addr_out;
  logic          mem_we_out;
  logic [DW-1:0] mem_wdata_out;
  logic [DW-1:0] mem_rdata_in = '0;

  int total = 0;
  int bad = 0;
  int edge_n;

  logic [7:0] ram [0:4095];

  vga_vram_port #(.AW(AW), .DW(DW)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .vid_address_in (vid_address_in),
    .vid_data_out   (vid_data_out),
    .vid_blank_in   (vid_blank_in),
    .host_req_in    (host_req_in),
    .host_we_in     (host_we_in),
    .host_addr_in   (host_addr_in),
    .host_wdata_in  (host_wdata_in),
    .host_busy_out  (host_busy_out),
    .host_ack_out   (host_ack_out),
    .host_rdata_out (host_rdata_out),
    .mem_addr_out   (mem_addr_out),
    .mem_we_out     (mem_we_out),
    .mem_wdata_out  (mem_wdata_out),
    .mem_rdata_in   (mem_rdata_in)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous RAM: read data valid the cycle after the address is sampled.
  always @(posedge clk_in) begin
    if (mem_we_out) ram[mem_addr_out[11:0]] <= mem_wdata_out;
    mem_rdata_in <= ram[mem_addr_out[11:0]];
  end

  // Edges since reset release; edge k is a host issue edge when k is odd.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  // Land on a negedge whose following posedge is a video (1) or host (0) issue edge.
  task automatic wait_phase(input bit vie);
    @(negedge clk_in);
    if (((edge_n % 2) == 1) != vie) @(negedge clk_in);
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // One host access starting at the current negedge; checks latency,
  // write-enable width, ack pulse, busy and optional undisturbed video.
  task automatic host_access(input string name, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input int exp_lat,
                             input bit chk_rd, input logic [DW-1:0] exp_rd,
                             input logic [DW-1:0] exp_vid);
    int lat = 0;
    int we_cycles = 0;
    int vid_bad = 0;
    bit got = 0;
    host_req_in = 1'b1; host_we_in = we; host_addr_in = addr; host_wdata_in = wdata;
    @(negedge clk_in);
    host_req_in = 1'b0;
    cmp({name, "_busy_set"}, 32'(host_busy_out), 32'd1);
    while (lat < 10 && !got) begin
      @(negedge clk_in);
      lat++;
      if (mem_we_out) we_cycles++;
      if (vid_data_out !== exp_vid) vid_bad++;
      got = host_ack_out;
    end
    cmp({name, "_ack_seen"}, 32'(got), 32'd1);
    cmp({name, "_latency"}, 32'(lat), 32'(exp_lat));
    cmp({name, "_we_cycles"}, 32'(we_cycles), we ? 32'd1 : 32'd0);
    cmp({name, "_busy_in_ack"}, 32'(host_busy_out), 32'd0);
    cmp({name, "_video_held"}, 32'(vid_bad), 32'd0);
    if (chk_rd) cmp({name, "_rdata"}, 32'(host_rdata_out), 32'(exp_rd));
    @(negedge clk_in);
    cmp({name, "_ack_one_cycle"}, 32'(host_ack_out), 32'd0);
  endtask

  task automatic settle_video(input logic [AW-1:0] addr);
    vid_address_in = addr;
    repeat (5) @(negedge clk_in);
  endtask

  task automatic test_reset;
    #12;
    cmp("rst_vid_data", 32'(vid_data_out), 32'd0);
    cmp("rst_busy", 32'(host_busy_out), 32'd0);
    cmp("rst_ack", 32'(host_ack_out), 32'd0);
    cmp("rst_rdata", 32'(host_rdata_out), 32'd0);
    cmp("rst_mem_addr", 32'(mem_addr_out), 32'd0);
    cmp("rst_mem_we", 32'(mem_we_out), 32'd0);
    cmp("rst_mem_wdata", 32'(mem_wdata_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_video_stream;
    logic [7:0] e;
    wait_phase(1);
    for (int k = 0; k < 10; k++) begin
      vid_address_in = 24'h000100 + 24'(k);
      if (k >= 2) begin
        e = 8'(k - 2) ^ 8'h5A;
        cmp($sformatf("video_hold_%0d", k - 2), 32'(vid_data_out), 32'(e));
      end
      @(negedge clk_in);
      if (k >= 1) begin
        e = 8'(k - 1) ^ 8'h5A;
        cmp($sformatf("video_new_%0d", k - 1), 32'(vid_data_out), 32'(e));
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_write_read;
    settle_video(24'h000105);
    wait_phase(1);
    host_access("wr_c3", 1'b1, 24'h0012C0, 8'hC3, 3, 1'b0, 8'h00, 8'h5F);
    wait_phase(0);
    host_access("rd_c3", 1'b0, 24'h0012C0, 8'h00, 4, 1'b1, 8'hC3, 8'h5F);
    cmp("video_after_host", 32'(vid_data_out), 32'h5F);
  endtask

  task automatic test_request_phase;
    wait_phase(1);
    host_access("phase_vie", 1'b0, 24'h000110, 8'h00, 3, 1'b1, 8'h4A, 8'h5F);
    wait_phase(0);
    host_access("phase_hie", 1'b1, 24'h000111, 8'hA5, 4, 1'b0, 8'h00, 8'h5F);
    wait_phase(0);
    host_access("phase_hie_rd", 1'b0, 24'h000111, 8'h00, 4, 1'b1, 8'hA5, 8'h5F);
  endtask

  task automatic test_back_to_back;
    int acks = 0;
    int guard = 0;
    int last;
    int bad_busy = 0;
    wait_phase(1);
    last = edge_n;
    host_req_in = 1'b1; host_we_in = 1'b0; host_addr_in = 24'h0012C0;
    while (acks < 3 && guard < 40) begin
      @(negedge clk_in);
      guard++;
      if (host_ack_out) begin
        cmp($sformatf("b2b_spacing_%0d", acks), 32'(edge_n - last), 32'd4);
        cmp($sformatf("b2b_busy_clear_%0d", acks), 32'(host_busy_out), 32'd0);
        cmp($sformatf("b2b_rdata_%0d", acks), 32'(host_rdata_out), 32'hC3);
        last = edge_n;
        acks++;
        if (acks == 3) host_req_in = 1'b0;
      end else if (host_busy_out !== 1'b1) begin
        bad_busy++;
      end
    end
    cmp("b2b_ack_count", 32'(acks), 32'd3);
    cmp("b2b_busy_gaps", 32'(bad_busy), 32'd0);
    @(negedge clk_in);
    cmp("b2b_idle_after", 32'(host_busy_out), 32'd0);
  endtask

  task automatic test_blanking;
    settle_video(24'h000106);
    vid_blank_in = 1'b1;
    wait_phase(0);
`ifdef VRAM_VBLANK_HOST_EN
    host_access("blank_wr", 1'b1, 24'h0012C1, 8'h3C, 3, 1'b0, 8'h00, 8'h5C);
`else
    host_access("blank_wr", 1'b1, 24'h0012C1, 8'h3C, 4, 1'b0, 8'h00, 8'h5C);
`endif
    settle_video(24'h000107);
    cmp("blank_video_runs", 32'(vid_data_out), 32'h5D);
    vid_blank_in = 1'b0;
    wait_phase(1);
    host_access("blank_rd", 1'b0, 24'h0012C1, 8'h00, 3, 1'b1, 8'h3C, 8'h5D);
  endtask

  task automatic test_reset_mid_write;
    int n = 0;
    int late_ack = 0;
    settle_video(24'h000105);
    cmp("rst2_video_before", 32'(vid_data_out), 32'h5F);
    wait_phase(1);
    host_req_in = 1'b1; host_we_in = 1'b1; host_addr_in = 24'h0012C2; host_wdata_in = 8'h77;
    @(negedge clk_in);
    host_req_in = 1'b0;
    while (n < 6 && mem_we_out !== 1'b1) begin
      @(negedge clk_in);
      n++;
    end
    cmp("rst2_we_seen", 32'(mem_we_out), 32'd1);
    #2 rst_in = 1'b1;
    #1;
    cmp("rst2_mem_we", 32'(mem_we_out), 32'd0);
    cmp("rst2_mem_addr", 32'(mem_addr_out), 32'd0);
    cmp("rst2_mem_wdata", 32'(mem_wdata_out), 32'd0);
    cmp("rst2_vid_data", 32'(vid_data_out), 32'd0);
    cmp("rst2_busy", 32'(host_busy_out), 32'd0);
    cmp("rst2_rdata", 32'(host_rdata_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (8) begin
      @(negedge clk_in);
      if (host_ack_out !== 1'b0 || host_busy_out !== 1'b0) late_ack++;
    end
    cmp("rst2_no_ack_after", 32'(late_ack), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i) ^ 8'h5A;
    test_reset;
    test_video_stream;
    test_write_read;
    test_request_phase;
    test_back_to_back;
    test_blanking;
    test_reset_mid_write;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
